pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 6, program-counter width in bits.
REQ-002 SHALL have parameter OFF_W, default 6, signed branch-offset width (OFF_W <= PC_W).
REQ-003 SHALL have parameter STACK_DEPTH, default 4, number of return-address entries (power of two, >= 2).
REQ-004 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-005 SHALL have clk_main, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have en, input, 1, advance enable; 0 = stall.
REQ-008 SHALL have ps, input, 3, PC-select opcode.
REQ-009 SHALL have a, input, PC_W, absolute jump/call target.
REQ-010 SHALL have off, input, OFF_W, two's-complement branch offset.
REQ-011 SHALL have pc, output, PC_W, registered program counter.
REQ-012 SHALL have stack_full, output, 1, high when STACK_DEPTH entries are held.
REQ-013 SHALL have stack_empty, output, 1, high when zero entries are held.
REQ-014 SHALL have ovf, output, 1, sticky flag: CALL attempted while full.
REQ-015 SHALL have unf, output, 1, sticky flag: RET attempted while empty.

Function
REQ-016 With en=1, ps SHALL select: 000 HOLD pc<=pc; 001 INC pc<=pc+1; 010 BRANCH pc<=pc+sext(off)+1; 011 JUMP pc<=a; 100 CALL push pc+1, pc<=a; 101 RET pc<=top, pop.
REQ-017 Opcodes 110 and 111 SHALL behave as HOLD, with no flag or stack change.
REQ-018 All PC arithmetic SHALL be modulo 2^PC_W; off is sign-extended to PC_W (e.g. 0 + (-1) + 1 = 0; max + 1 = 0).
REQ-019 Each update SHALL be one-cycle latency: the new pc is visible the cycle after the opcode edge.
REQ-020 With en=0, pc, stack contents, stack pointer and flags SHALL hold regardless of ps.
REQ-021 CALL when full SHALL still load pc<=a, SHALL NOT push or overwrite any entry, and SHALL set ovf.
REQ-022 RET when empty SHALL perform INC (pc<=pc+1), SHALL leave the stack pointer unchanged, and SHALL set unf.
REQ-023 The stack SHALL be LIFO; stack_full and stack_empty SHALL be registered and SHALL reflect the pointer after each update.
REQ-024 ovf and unf SHALL clear only on reset.

Reset
REQ-025 reset=1 at a clock edge SHALL set pc=RESET_PC, stack pointer=0, stack_empty=1, stack_full=0, ovf=0, unf=0; reset SHALL take priority over en and ps.
REQ-026 Reset mid-sequence (e.g. with stack entries pending) SHALL discard all entries; stack RAM contents need not be cleared.

Configuration
REQ-027 Macro PC_SEQUENCER_STACK_EN SHALL, when defined, compile in the return-address stack and REQ-021/022 behaviour.
REQ-028 Without PC_SEQUENCER_STACK_EN: CALL SHALL behave as JUMP, RET as INC, stack_full=0, stack_empty=1, ovf=0, unf=0 constantly, and no stack storage SHALL be synthesised.

Structure
REQ-029 Package pc_pkg SHALL hold the ps opcode constants (PS_HOLD, PS_INC, PS_BRANCH, PS_JUMP, PS_CALL, PS_RET) and the PS_W=3 constant.
REQ-030 The stack SHALL be a sub-module pc_ret_stack (push, pop, data in/out, full, empty), instantiated only under PC_SEQUENCER_STACK_EN.

Verification
REQ-031 Reset then 3 cycles of INC -> pc 0,1,2,3; hold reset with ps=INC -> pc stays 0.
REQ-032 pc=10, BRANCH off=-5 (6'b111011) -> pc=6; pc=63, INC -> pc=0 (wrap).
REQ-033 pc=5, CALL a=40; pc=40, CALL a=20; then RET, RET -> pc 40, 20, 41, 6; stack_empty=1 at the end.
REQ-034 Five CALLs with a=8 from pc=1 (depth 4) -> stack_full after the 4th call, ovf=1 after the 5th, pc=8; four RETs pop 9,9,9,2.
REQ-035 RET on an empty stack at pc=7 -> pc=8, unf=1; en=0 with ps=JUMP, a=30 -> pc unchanged.
REQ-036 Build without the macro: CALL a=12 -> pc=12; RET -> pc=13; stack_empty=1, ovf=unf=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared PC-select opcodes and widths for the pc_sequencer slice.
package pc_pkg;

   localparam int unsigned PS_W = 3;

   localparam logic [PS_W-1:0] PS_HOLD   = 3'b000;
   localparam logic [PS_W-1:0] PS_INC    = 3'b001;
   localparam logic [PS_W-1:0] PS_BRANCH = 3'b010;
   localparam logic [PS_W-1:0] PS_JUMP   = 3'b011;
   localparam logic [PS_W-1:0] PS_CALL   = 3'b100;
   localparam logic [PS_W-1:0] PS_RET    = 3'b101;

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO return-address stack with registered full/empty flags.
// Push while full and pop while empty are ignored.
module pc_ret_stack #(
   parameter int unsigned DATA_W = 6,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk_main,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout_c,
   output logic              full,
   output logic              empty
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned SP_W  = IDX_W + 1;

   logic [SP_W-1:0]   sp;
   logic [SP_W-1:0]   sp_nxt;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              do_push;
   logic              do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign wr_idx  = sp[IDX_W-1:0];
   assign rd_idx  = IDX_W'(sp - SP_W'(1));
   assign dout_c  = mem[rd_idx];

   always_comb begin
      sp_nxt = sp;
      if (do_push) begin
         sp_nxt = sp + SP_W'(1);
      end else if (do_pop) begin
         sp_nxt = sp - SP_W'(1);
      end
   end

   // Flags are computed from the next pointer so they track sp exactly.
   always_ff @(posedge clk_main) begin
      if (reset) begin
         sp    <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         sp    <= sp_nxt;
         full  <= (sp_nxt == SP_W'(DEPTH));
         empty <= (sp_nxt == '0);
      end
   end

   // Storage is not reset; the pointer alone defines validity.
   always_ff @(posedge clk_main) begin
      if (!reset && do_push) begin
         mem[wr_idx] <= din;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: hold/inc/branch/jump/call/ret.
// Define PC_SEQUENCER_STACK_EN to build in the return-address stack.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int unsigned PC_W        = 6,
   parameter int unsigned OFF_W       = 6,
   parameter int unsigned STACK_DEPTH = 4,
   parameter int unsigned RESET_PC    = 0
) (
   input  logic             clk_main,
   input  logic             reset,
   input  logic             en,
   input  logic [PS_W-1:0]  ps,
   input  logic [PC_W-1:0]  a,
   input  logic [OFF_W-1:0] off,
   output logic [PC_W-1:0]  pc,
   output logic             stack_full,
   output logic             stack_empty,
   output logic             ovf,
   output logic             unf
);

   if (OFF_W > PC_W || STACK_DEPTH < 2 ||
       (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_param_chk
      $error("pc_sequencer: illegal parameter combination");
   end

   logic [PC_W-1:0] pc_nxt;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] off_ext;

   assign pc_inc  = pc + PC_W'(1);
   assign off_ext = PC_W'($signed(off));

`ifdef PC_SEQUENCER_STACK_EN
   logic            stk_push;
   logic            stk_pop;
   logic            stk_full;
   logic            stk_empty;
   logic [PC_W-1:0] stk_top_c;

   assign stk_push = en && (ps == PS_CALL);
   assign stk_pop  = en && (ps == PS_RET);

   pc_ret_stack #(
      .DATA_W (PC_W),
      .DEPTH  (STACK_DEPTH)
   ) u_ret_stack (
      .clk_main (clk_main),
      .reset    (reset),
      .push     (stk_push),
      .pop      (stk_pop),
      .din      (pc_inc),
      .dout_c   (stk_top_c),
      .full     (stk_full),
      .empty    (stk_empty)
   );

   assign stack_full  = stk_full;
   assign stack_empty = stk_empty;

   // Sticky misuse flags; only reset clears them.
   always_ff @(posedge clk_main) begin
      if (reset) begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end else if (en) begin
         if (ps == PS_CALL && stk_full) begin
            ovf <= 1'b1;
         end
         if (ps == PS_RET && stk_empty) begin
            unf <= 1'b1;
         end
      end
   end
`else
   assign stack_full  = 1'b0;
   assign stack_empty = 1'b1;
   assign ovf         = 1'b0;
   assign unf         = 1'b0;
`endif

   always_comb begin
      pc_nxt = pc;
      if (en) begin
         case (ps)
            PS_INC:    pc_nxt = pc_inc;
            PS_BRANCH: pc_nxt = pc_inc + off_ext;
            PS_JUMP:   pc_nxt = a;
            PS_CALL:   pc_nxt = a;
`ifdef PC_SEQUENCER_STACK_EN
            PS_RET:    pc_nxt = stk_empty ? pc_inc : stk_top_c;
`else
            PS_RET:    pc_nxt = pc_inc;
`endif
            default:   pc_nxt = pc;
         endcase
      end
   end

   always_ff @(posedge clk_main) begin
      if (reset) begin
         pc <= PC_W'(RESET_PC);
      end else begin
         pc <= pc_nxt;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_pc_sequencer;

   localparam int unsigned PC_W  = 6;
   localparam int unsigned OFF_W = 6;
   localparam int unsigned DEPTH = 4;
   localparam int          MODV  = 64;

   logic             clk_main = 1'b0;
   logic             reset    = 1'b1;
   logic             en       = 1'b0;
   logic [2:0]       ps       = 3'd0;
   logic [PC_W-1:0]  a        = '0;
   logic [OFF_W-1:0] off      = '0;
   logic [PC_W-1:0]  pc;
   logic             stack_full;
   logic             stack_empty;
   logic             ovf;
   logic             unf;

   int n_cmp = 0;
   int n_err = 0;

   int m_pc  = 0;
   int m_ovf = 0;
   int m_unf = 0;
   int stk[$];

   pc_sequencer #(
      .PC_W        (PC_W),
      .OFF_W       (OFF_W),
      .STACK_DEPTH (DEPTH),
      .RESET_PC    (0)
   ) dut (
      .clk_main    (clk_main),
      .reset       (reset),
      .en          (en),
      .ps          (ps),
      .a           (a),
      .off         (off),
      .pc          (pc),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .ovf         (ovf),
      .unf         (unf)
   );

   always #5 clk_main = ~clk_main;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
      end
   endtask

   function automatic int wrap(input int v);
      return ((v % MODV) + MODV) % MODV;
   endfunction

   // Reference behaviour straight from the opcode table.
   task automatic model_step(input logic r, input logic e, input logic [2:0] p,
                             input int av, input int ov);
      int soff;
      soff = (ov >= 32) ? ov - 64 : ov;
      if (r) begin
         m_pc = 0;
         m_ovf = 0;
         m_unf = 0;
         stk.delete();
      end else if (e) begin
         case (p)
            3'd1: m_pc = wrap(m_pc + 1);
            3'd2: m_pc = wrap(m_pc + soff + 1);
            3'd3: m_pc = av;
            3'd4: begin
`ifdef PC_SEQUENCER_STACK_EN
               if (stk.size() < DEPTH) stk.push_back(wrap(m_pc + 1));
               else m_ovf = 1;
`endif
               m_pc = av;
            end
            3'd5: begin
`ifdef PC_SEQUENCER_STACK_EN
               if (stk.size() > 0) m_pc = stk.pop_back();
               else begin
                  m_pc = wrap(m_pc + 1);
                  m_unf = 1;
               end
`else
               m_pc = wrap(m_pc + 1);
`endif
            end
            default: ;
         endcase
      end
   endtask

   task automatic cycle(input logic r, input logic e, input logic [2:0] p,
                        input int av, input int ov);
      reset = r;
      en    = e;
      ps    = p;
      a     = PC_W'(av);
      off   = OFF_W'(ov);
      @(posedge clk_main);
      model_step(r, e, p, av, ov);
      #1;
      check("pc", int'(pc), m_pc);
      check("stack_full", int'(stack_full), int'(stk.size() == DEPTH));
      check("stack_empty", int'(stack_empty), int'(stk.size() == 0));
      check("ovf", int'(ovf), m_ovf);
      check("unf", int'(unf), m_unf);
   endtask

   initial begin
      // Reset held with INC pending keeps pc at reset value
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1, 3'd1, 0, 0);
         check("rst_pc", int'(pc), 0);
      end
      check("rst_empty", int'(stack_empty), 1);
      check("rst_full", int'(stack_full), 0);
      for (int i = 1; i <= 3; i++) begin
         cycle(1'b0, 1'b1, 3'd1, 0, 0);
         check("inc_pc", int'(pc), i);
      end

      // Negative branch and wrap at the top of the PC range
      cycle(1'b0, 1'b1, 3'd3, 10, 0);
      cycle(1'b0, 1'b1, 3'd2, 0, 6'b111011);
      check("branch_neg", int'(pc), 6);
      cycle(1'b0, 1'b1, 3'd3, 63, 0);
      cycle(1'b0, 1'b1, 3'd1, 0, 0);
      check("inc_wrap", int'(pc), 0);
      cycle(1'b0, 1'b1, 3'd2, 0, 6'b111111);
      check("branch_m1", int'(pc), 0);

      // Nested call/return
      cycle(1'b0, 1'b1, 3'd3, 5, 0);
      cycle(1'b0, 1'b1, 3'd4, 40, 0);
      check("call1", int'(pc), 40);
      cycle(1'b0, 1'b1, 3'd4, 20, 0);
      check("call2", int'(pc), 20);
      cycle(1'b0, 1'b1, 3'd5, 0, 0);
`ifdef PC_SEQUENCER_STACK_EN
      check("ret1", int'(pc), 41);
      cycle(1'b0, 1'b1, 3'd5, 0, 0);
      check("ret2", int'(pc), 6);
`else
      check("ret1", int'(pc), 21);
      cycle(1'b0, 1'b1, 3'd5, 0, 0);
      check("ret2", int'(pc), 22);
`endif
      check("nest_empty", int'(stack_empty), 1);

      // Overflow then drain
      cycle(1'b1, 1'b0, 3'd0, 0, 0);
      cycle(1'b0, 1'b1, 3'd3, 1, 0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 3'd4, 8, 0);
      check("ovf_pc", int'(pc), 8);
`ifdef PC_SEQUENCER_STACK_EN
      check("ovf_flag", int'(ovf), 1);
      check("ovf_full", int'(stack_full), 1);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 3'd5, 0, 0);
         check("drain", int'(pc), (i == 3) ? 2 : 9);
      end
`else
      check("ovf_flag", int'(ovf), 0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 3'd5, 0, 0);
         check("drain", int'(pc), 9 + i);
      end
`endif

      // Underflow and stall
      cycle(1'b1, 1'b0, 3'd0, 0, 0);
      cycle(1'b0, 1'b1, 3'd3, 7, 0);
      cycle(1'b0, 1'b1, 3'd5, 0, 0);
      check("unf_pc", int'(pc), 8);
`ifdef PC_SEQUENCER_STACK_EN
      check("unf_flag", int'(unf), 1);
`else
      check("unf_flag", int'(unf), 0);
`endif
      cycle(1'b0, 1'b0, 3'd3, 30, 0);
      check("stall_pc", int'(pc), 8);

      // Flat build: CALL acts as JUMP, RET as INC
      cycle(1'b0, 1'b1, 3'd4, 12, 0);
      check("call12", int'(pc), 12);
      cycle(1'b0, 1'b1, 3'd5, 0, 0);
`ifndef PC_SEQUENCER_STACK_EN
      check("ret13", int'(pc), 13);
`endif

      // Randomized traffic, call/ret-heavy to exercise stack boundaries
      for (int i = 0; i < 600; i++) begin
         logic       r;
         logic       e;
         logic [2:0] p;
         int         sel;
         r   = ($urandom_range(0, 99) < 2);
         e   = ($urandom_range(0, 99) < 80);
         sel = $urandom_range(0, 11);
         p   = (sel >= 8) ? ((sel[0]) ? 3'd4 : 3'd5) : 3'(sel);
         cycle(r, e, p, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
